// File: rtl/jelly_fifo_write_credit.sv
// Stream-to-FIFO write adapter: credit counter over a lagging free count,
// plus a one-word skid buffer so s_ready stays registered.
module jelly_fifo_write_credit #(
  parameter int DATA_WIDTH   = 8,
  parameter int PTR_WIDTH    = 10,
  parameter int FREE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [PTR_WIDTH:0]    s_free_count,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_WIDTH:0]    wr_free_count
);
  localparam int L  = FREE_LATENCY;
  localparam int CW = $clog2(L + 1);

  logic [L-1:0]          hist_q, hist_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  s_ready_q, s_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [PTR_WIDTH:0]    inflight_ext;
  logic                  credit_ok;
  logic                  accept;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  issue;

  // Writes still invisible in wr_free_count must be subtracted before spending a credit.
  assign inflight_ext = (PTR_WIDTH + 1)'(inflight_q);
  assign credit_ok    = (wr_free_count > inflight_ext);
  assign s_free_count = credit_ok ? (wr_free_count - inflight_ext) : '0;

  assign s_ready = s_ready_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;

  always_comb begin
    accept     = s_valid & s_ready_q;
    head_valid = skid_valid_q | accept;
    head_data  = skid_valid_q ? skid_q : s_data;
    issue      = head_valid & credit_ok;

    wr_en_d      = issue;
    wr_data_d    = issue ? head_data : wr_data_q;
    // A held skid word keeps s_ready low, so the head is either the skid or the input.
    skid_valid_d = head_valid & ~issue;
    skid_d       = (accept & ~issue) ? s_data : skid_q;
    s_ready_d    = ~skid_valid_d;

    hist_d     = L'({hist_q, wr_en_d});
    inflight_d = inflight_q + CW'(wr_en_d) - CW'(hist_q[L-1]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q       <= '0;
      inflight_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      s_ready_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      hist_q       <= hist_d;
      inflight_q   <= inflight_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      s_ready_q    <= s_ready_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_jelly_fifo_write_credit.sv
// Bench: two adapters (free-count lag 1 and 3) on 16-entry FIFO models,
// checked cycle by cycle against a pending-word/credit reference model.
module tb_jelly_fifo_write_credit;
  localparam int DW = 8, PW = 4, DEPTH = 16, NCYC = 2000;
  localparam int L0 = 1, L1 = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic [DW-1:0] s_data [2];
  logic          s_valid [2];
  logic          s_ready [2];
  logic [PW:0]   s_free [2];
  logic          wr_en [2];
  logic [DW-1:0] wr_data [2];
  logic [PW:0]   wr_free [2];

  always #5 clk = ~clk;

  jelly_fifo_write_credit #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .FREE_LATENCY(L0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .s_free_count(s_free[0]), .wr_en(wr_en[0]),
    .wr_data(wr_data[0]), .wr_free_count(wr_free[0]));

  jelly_fifo_write_credit #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .FREE_LATENCY(L1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .s_free_count(s_free[1]), .wr_en(wr_en[1]),
    .wr_data(wr_data[1]), .wr_free_count(wr_free[1]));

  int checks = 0;
  int errors = 0;

  // reference model: accepted-but-unwritten words and the scheduled write
  bit          m_ready [2];
  bit          m_wen [2];
  logic [DW-1:0] m_wdata [2];
  int          m_pend_n [2];
  logic [DW-1:0] m_pend_w [2];
  bit          m_wlog [2][NCYC];
  bit          m_rst_prev;
  int          cyc, rst_start;

  // FIFO model
  int occ [2], rtot [2], rd_budget [2], nwr [2];
  int wcum [2][NCYC];

  // stimulus controls
  int next_word [2];
  int prod_lim, vprob, rprob, data_fix;
  bit data_rand, force1;

  function automatic int lat(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] cyc=%0d obs=%0h exp=%0h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic do_cycle(input logic rst);
    int wl, wlag, infl, vis, n;
    int free [2];
    int inf [2];
    logic acc;
    logic [DW-1:0] head;
    reset_n = ~rst;
    for (int k = 0; k < 2; k++) begin
      wl = cyc - lat(k);
      wlag = (wl >= rst_start) ? wcum[k][wl] : 0;
      free[k] = force1 ? 1 : DEPTH - wlag + rtot[k];
      wr_free[k] = (PW + 1)'(free[k]);
      s_valid[k] = (next_word[k] < prod_lim) && ($urandom_range(99) < vprob);
      s_data[k] = (data_fix >= 0) ? DW'(data_fix) : (data_rand ? DW'($urandom) : DW'(next_word[k]));
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      infl = 0;
      for (int w = cyc - lat(k) + 1; w <= cyc; w++)
        if (w >= rst_start && m_wlog[k][w]) infl++;
      inf[k] = infl;
      chk("s_ready", k, 32'(s_ready[k]), 32'(m_ready[k]));
      chk("wr_en", k, 32'(wr_en[k]), 32'(m_wen[k]));
      chk("s_free_count", k, 32'(s_free[k]), (free[k] > infl) ? 32'(free[k] - infl) : 32'd0);
      if (m_wen[k] || m_rst_prev) chk("wr_data", k, 32'(wr_data[k]), 32'(m_wdata[k]));
      if (!force1 && wr_en[k] === 1'b1) chk("overflow", k, 32'(occ[k] >= DEPTH), 32'd0);

      // FIFO side: reads only of entries already visible through the lagged count
      wl = cyc - lat(k);
      wlag = (wl >= rst_start) ? wcum[k][wl] : 0;
      vis = wlag - rtot[k];
      if (rd_budget[k] > 0 && vis > 0 && $urandom_range(99) < rprob) begin
        occ[k]--; rtot[k]++; rd_budget[k]--;
      end
      if (wr_en[k] === 1'b1) begin
        occ[k]++; nwr[k]++;
      end
      wcum[k][cyc] = ((cyc > rst_start) ? wcum[k][cyc-1] : 0) + ((wr_en[k] === 1'b1) ? 1 : 0);

      if (rst) begin
        m_wen[k] = 1'b0; m_wdata[k] = '0; m_pend_n[k] = 0; m_ready[k] = 1'b0;
        occ[k] = 0; rtot[k] = 0;
      end else begin
        acc  = s_valid[k] && m_ready[k];
        n    = m_pend_n[k] + (acc ? 1 : 0);
        head = (m_pend_n[k] > 0) ? m_pend_w[k] : s_data[k];
        if (acc) next_word[k]++;
        if (n > 0 && free[k] > inf[k]) begin
          m_wen[k] = 1'b1; m_wdata[k] = head; n--;
        end else begin
          m_wen[k] = 1'b0;
        end
        if (n > 0) m_pend_w[k] = head;
        m_pend_n[k] = n;
        m_ready[k] = (n == 0);
      end
    end
    m_rst_prev = rst;
    if (rst) rst_start = cyc + 1;
    cyc++;
    for (int k = 0; k < 2; k++) m_wlog[k][cyc] = m_wen[k];
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid[k] = 1'b0; s_data[k] = '0; wr_free[k] = (PW + 1)'(DEPTH);
      m_ready[k] = 1'b0; m_wen[k] = 1'b0; m_wdata[k] = '0; m_pend_n[k] = 0; m_pend_w[k] = '0;
      occ[k] = 0; rtot[k] = 0; rd_budget[k] = 0; nwr[k] = 0; next_word[k] = 0;
    end
    m_rst_prev = 1'b1; cyc = 0; rst_start = 0;
    vprob = 100; rprob = 100; data_fix = 8'hAA; prod_lim = 1000000; data_rand = 1'b0; force1 = 1'b0;
    @(posedge clk);
    #1;

    // reset hold with a valid input pending
    repeat (3) do_cycle(1'b1);

    // fill to full: words 0..19, no reads
    data_fix = -1; prod_lim = 20;
    for (int k = 0; k < 2; k++) begin next_word[k] = 0; nwr[k] = 0; end
    repeat (40) do_cycle(1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("fill_writes", k, 32'(nwr[k]), 32'd16);
      chk("fill_ready_low", k, 32'(s_ready[k]), 32'd0);
    end

    // drain: read 4 entries, words 16..19 follow
    for (int k = 0; k < 2; k++) rd_budget[k] = 4;
    repeat (30) do_cycle(1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("drain_writes", k, 32'(nwr[k]), 32'd20);
      chk("drain_ready_high", k, 32'(s_ready[k]), 32'd1);
    end

    // single credit: free count pinned at 1, continuous valid
    force1 = 1'b1; prod_lim = 1000000;
    do_cycle(1'b1);
    for (int k = 0; k < 2; k++) begin next_word[k] = 0; nwr[k] = 0; rd_budget[k] = 0; end
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b0);
      for (int k = 0; k < 2; k++)
        if (i == lat(k) + 1) chk("single_credit_writes", k, 32'(nwr[k]), 32'd1);
    end

    // reset mid-burst with the skid occupied
    force1 = 1'b0;
    do_cycle(1'b1);
    repeat (25) do_cycle(1'b0);
    for (int k = 0; k < 2; k++) chk("skid_full_ready_low", k, 32'(s_ready[k]), 32'd0);
    do_cycle(1'b1);
    for (int k = 0; k < 2; k++) rd_budget[k] = 1000000;
    rprob = 50;
    repeat (20) do_cycle(1'b0);

    // randomized traffic with occasional resets
    data_rand = 1'b1; vprob = 70; rprob = 40;
    repeat (600) do_cycle($urandom_range(199) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
